// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser_pkg
// Description : Shared constants, state encoding and helpers for the serial
//               byte deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package deser_pkg;

    localparam int         BITS_PER_BYTE     = 8;
    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;
    localparam int         DEFAULT_TIMEOUT   = 64;

    // Receiver state encoding; HUNT is only reachable in the sync-word build
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RECV = 2'd2
    } state_t;

    // Shift one serial bit into the byte window, MSB first
    function automatic logic [BITS_PER_BYTE-1:0] shift_in(
        input logic [BITS_PER_BYTE-1:0] cur,
        input logic                     b
    );
        return {cur[BITS_PER_BYTE-2:0], b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Two-flop synchronizer for an asynchronous strobe plus a
//               companion level signal. Produces a registered rising-edge
//               pulse of the strobe and the level signal delayed by the same
//               amount, so the two outputs stay cycle-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst,           // synchronous, active-low
    input  logic i_edge_src,    // asynchronous strobe (edge detected)
    input  logic i_level_src,   // asynchronous level carried alongside
    output logic o_rise,        // one-cycle pulse per strobe rising edge
    output logic o_level        // level sampled with the edge
);

    logic r_edge_s1;
    logic r_edge_s2;
    logic r_edge_s3;
    logic r_lvl_s1;
    logic r_lvl_s2;
    logic r_rise;
    logic r_level;

    // Synchronize both inputs, detect the strobe edge and register it with the level
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_edge_s1 <= 1'b0;
            r_edge_s2 <= 1'b0;
            r_edge_s3 <= 1'b0;
            r_lvl_s1  <= 1'b0;
            r_lvl_s2  <= 1'b0;
            r_rise    <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_edge_s1 <= i_edge_src;
            r_edge_s2 <= r_edge_s1;
            r_edge_s3 <= r_edge_s2;
            r_lvl_s1  <= i_level_src;
            r_lvl_s2  <= r_lvl_s1;
            r_rise    <= r_edge_s2 & ~r_edge_s3;
            r_level   <= r_lvl_s2;
        end
    end

    assign o_rise  = r_rise;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Rebuilds MSB-first serial bytes (rxclk/rx) in the clk domain
//               and presents them on a valid/ready interface. Partial bytes
//               are dropped after TIMEOUT clk cycles without an rxclk edge.
//               Optional macro DESER_SYNC_EN adds a HUNT state that waits for
//               SYNC_WORD before byte framing starts.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer
    import deser_pkg::*;
#(
    parameter int         TIMEOUT   = DEFAULT_TIMEOUT
`ifdef DESER_SYNC_EN
   ,parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD
`endif
) (
    input  logic       clk,
    input  logic       rst,       // synchronous, active-low
    input  logic       en,
    input  logic       rxclk,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun
);

    localparam int CNT_W = $clog2(BITS_PER_BYTE);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(BITS_PER_BYTE - 1);
    localparam logic [TMO_W-1:0] c_tmo_max  = TMO_W'(TIMEOUT);

    state_t                   r_state;
    logic [BITS_PER_BYTE-1:0] r_shift;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic [TMO_W-1:0]         r_tmo;
    logic [7:0]               r_data;
    logic                     r_valid;
    logic                     r_overrun;

    logic                     w_rise;
    logic                     w_rx;
    logic [BITS_PER_BYTE-1:0] w_window;
    logic [TMO_W-1:0]         w_tmo_inc;

    sync_edge_detect u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_edge_src  (rxclk),
        .i_level_src (rx),
        .o_rise      (w_rise),
        .o_level     (w_rx)
    );

    assign w_window  = shift_in(r_shift, w_rx);
    assign w_tmo_inc = (r_tmo == c_tmo_max) ? c_tmo_max : r_tmo + TMO_W'(1);

    // Receive FSM: framing, byte hand-off, overrun flag and gap timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tmo     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Consumer handshake; a byte loaded below in the same cycle wins
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (!en) begin
                // Any partial byte is abandoned; pending output stays drainable
                r_state   <= IDLE;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_tmo     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_tmo     <= '0;
`ifdef DESER_SYNC_EN
                        r_state   <= HUNT;
`else
                        r_state   <= RECV;
`endif
                    end
`ifdef DESER_SYNC_EN
                    HUNT: begin
                        // Slide the window bit by bit until the alignment byte appears
                        if (w_rise) begin
                            r_tmo   <= '0;
                            r_shift <= w_window;
                            if (w_window == SYNC_WORD) begin
                                r_state   <= RECV;
                                r_bit_cnt <= '0;
                            end
                        end else begin
                            r_tmo <= w_tmo_inc;
                        end
                    end
`endif
                    RECV: begin
                        if (w_rise) begin
                            r_tmo   <= '0;
                            r_shift <= w_window;
                            if (r_bit_cnt == c_last_bit) begin
                                r_bit_cnt <= '0;
                                if (!r_valid || ready) begin
                                    r_data  <= w_window;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end else begin
                            r_tmo <= w_tmo_inc;
                            // Line went quiet mid-byte: drop the fragment and re-frame
                            if ((w_tmo_inc == c_tmo_max) && (r_bit_cnt != '0)) begin
                                r_bit_cnt <= '0;
                                r_shift   <= '0;
`ifdef DESER_SYNC_EN
                                r_state   <= HUNT;
`endif
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer
// Description : Directed self-checking bench for deserializer. Drives rxclk/rx
//               as a divider-16 serializer would (8 clk low, 8 clk high per
//               bit, data changing on the falling edge) and records every
//               byte accepted through the valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rxclk;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       overrun;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rcv[$];

    deserializer dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .rxclk   (rxclk),
        .rx      (rx),
        .ready   (ready),
        .data    (data),
        .valid   (valid),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record a handshake seen before the coming posedge, then advance one cycle
    task automatic tick();
        if (valid === 1'b1 && ready === 1'b1) rcv.push_back(data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxclk = 1'b0;
        rx    = b;
        repeat (8) tick();
        rxclk = 1'b1;
        repeat (8) tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic line_idle(input int n);
        rxclk = 1'b0;
        repeat (n) tick();
    endtask

    // Alignment preamble needed only when the HUNT state exists
    task automatic send_sync();
`ifdef DESER_SYNC_EN
        send_byte(8'hA5);
`endif
    endtask

    initial begin
        rst   = 1'b0;
        en    = 1'b1;
        rxclk = 1'b0;
        rx    = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        repeat (4) tick();

        // Reset state
        check("reset_data",    data,           8'h00);
        check("reset_valid",   {7'd0, valid},   8'h00);
        check("reset_overrun", {7'd0, overrun}, 8'h00);
        rst = 1'b1;
        repeat (3) tick();
        send_sync();

        // Streaming 0x00..0x63 with ready held high
        ready = 1'b1;
        rcv.delete();
        for (int i = 0; i < 100; i++) send_byte(8'(i));
        line_idle(10);
        check("stream_count", 8'(rcv.size()), 8'd100);
        for (int i = 0; i < rcv.size(); i++) check("stream_byte", rcv[i], 8'(i));
        check("stream_overrun", {7'd0, overrun}, 8'h00);

        // Latency of 4 posedges, then backpressure and overrun
        ready = 1'b0;
        rcv.delete();
        for (int i = 7; i >= 1; i--) send_bit(8'h5A >> i);
        rxclk = 1'b0;
        rx    = 1'b0;
        repeat (8) tick();
        rxclk = 1'b1;
        repeat (3) tick();
        check("lat_valid_early", {7'd0, valid}, 8'h00);
        tick();
        check("lat_valid_on", {7'd0, valid}, 8'h01);
        check("lat_data", data, 8'h5A);
        repeat (4) tick();
        send_byte(8'hC3);
        line_idle(6);
        check("ovr_data",    data,             8'h5A);
        check("ovr_valid",   {7'd0, valid},    8'h01);
        check("ovr_overrun", {7'd0, overrun},  8'h01);
        ready = 1'b1;
        tick();
        check("drain_valid",   {7'd0, valid},   8'h00);
        check("drain_count",   8'(rcv.size()),  8'd1);
        check("drain_overrun", {7'd0, overrun}, 8'h01);

        // Partial byte followed by a long gap is discarded
        rcv.delete();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        line_idle(70);
        send_sync();
        send_byte(8'h81);
        line_idle(10);
        check("tmo_count", 8'(rcv.size()), 8'd1);
        if (rcv.size() > 0) check("tmo_byte", rcv[0], 8'h81);

        // Reset mid-byte while a byte is pending
        ready = 1'b0;
        rcv.delete();
        send_byte(8'h47);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        line_idle(2);
        check("pre_rst_valid", {7'd0, valid}, 8'h01);
        check("pre_rst_data",  data,          8'h47);
        rst = 1'b0;
        tick();
        check("rst_data",    data,            8'h00);
        check("rst_valid",   {7'd0, valid},   8'h00);
        check("rst_overrun", {7'd0, overrun}, 8'h00);
        rst = 1'b1;
        repeat (3) tick();
        send_sync();
        ready = 1'b1;
        send_byte(8'h6E);
        line_idle(10);
        check("post_rst_count", 8'(rcv.size()), 8'd1);
        if (rcv.size() > 0) check("post_rst_byte", rcv[0], 8'h6E);

        // Enable dropped mid-byte
        rcv.delete();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        line_idle(1);
        en = 1'b0;
        repeat (4) tick();
        en = 1'b1;
        repeat (3) tick();
        send_sync();
        send_byte(8'h3C);
        line_idle(10);
        check("en_count", 8'(rcv.size()), 8'd1);
        if (rcv.size() > 0) check("en_byte", rcv[0], 8'h3C);

`ifdef DESER_SYNC_EN
        // Hunt for the sync word: only bytes after it are delivered
        rcv.delete();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (3) tick();
        send_byte(8'h12);
        send_byte(8'hA5);
        send_byte(8'h77);
        send_byte(8'h88);
        line_idle(10);
        check("sync_count", 8'(rcv.size()), 8'd2);
        if (rcv.size() > 1) begin
            check("sync_byte0", rcv[0], 8'h77);
            check("sync_byte1", rcv[1], 8'h88);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the serializer stage.
- Consumes the serial bit clock (rxclk) and serial data (rx) produced by the serializer and rebuilds 8-bit bytes in the system clock domain.
- Presents each byte to downstream logic with a valid/ready handshake.
- Used in loopback benches and on the receive path of the SDR link.

Parameters:
- TIMEOUT, 64: clk cycles with no rxclk rising edge before a partial byte is discarded and the bit counter returns to 0.
- SYNC_WORD, 8'hA5: alignment byte; used only when DESER_SYNC_EN is defined.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- en  input  1  receive enable; low forces the IDLE state.
- rxclk  input  1  serial bit clock from the serializer; asynchronous to clk.
- rx  input  1  serial data; changes on rxclk falling edge, MSB first.
- ready  input  1  downstream accepts data this cycle.
- data  output  8  received byte.
- valid  output  1  data holds an unconsumed byte.
- overrun  output  1  sticky; a completed byte was dropped.

Behaviour:
- Reset (rst low at a clk posedge): data=0, valid=0, overrun=0, bit_cnt=0, shift=0, timeout counter=0, state=IDLE; synchronizer flops cleared.
- rxclk and rx each pass through a 2-flop synchronizer. A third rxclk flop forms the rising-edge detect (sync2 & ~sync3).
- rx is sampled from its sync2 flop in the cycle the edge is detected, so it is aligned with rxclk.
- rxclk high and low phases must each be at least 3 clk cycles. This is satisfied by serializer divider ≥ 6.
- States:
  - IDLE: entered when en=0 or on reset. Shift register and bit_cnt are cleared. data, valid and overrun are held, so the consumer can still drain a pending byte. en=1 -> RECV (or HUNT with the macro).
  - RECV: on each detected edge, shift = {shift[6:0], rx} and bit_cnt increments.
- Byte completion: on the 8th bit, the assembled byte {shift[6:0], rx} is ready and bit_cnt wraps to 0.
  - If valid=0, or valid=1 with ready=1 in the same cycle: data is loaded and valid=1 on the next clk edge.
  - Otherwise the new byte is dropped, data is unchanged, and overrun=1.
- Handshake: valid=1 and ready=1 -> valid=0 next cycle, unless a new byte loads in the same cycle (valid stays 1).
- Latency: valid rises 4 clk posedges after the 8th rxclk rising edge reaches the synchronizer input (2 sync + 1 detect + 1 register).
- Timeout: a counter increments on each clk cycle with no edge and clears on an edge. Reaching TIMEOUT with bit_cnt≠0 resets bit_cnt and shift, discarding the partial byte. The counter saturates at TIMEOUT.
- overrun clears only on reset.
- en falling mid-byte: partial byte discarded on the next cycle; no valid pulse.

Optional Feature:
- DESER_SYNC_EN defined:
  - Adds state HUNT, entered from IDLE and after a timeout.
  - In HUNT every edge shifts without counting.
  - When the 8-bit window equals SYNC_WORD -> RECV with bit_cnt=0. The sync byte itself is not output.
- Undefined: no HUNT state; alignment relies solely on the timeout gap.

Decomposition:
- Package deser_pkg holds:
  - BITS_PER_BYTE=8
  - DEFAULT_SYNC_WORD=8'hA5
  - DEFAULT_TIMEOUT=64
  - the state encoding (IDLE, HUNT, RECV)
- One sub-module, sync_edge_detect: 2-flop synchronizer plus rising-edge pulse and synchronized level output, with synchronous active-low reset. Instantiated for rxclk; rx uses its level output.

Test Plan:
- Serializer (divider 16) looped to deserializer, serializer fed an incrementing counter, ready tied 1 -> bytes 0x00..0x63 appear in order, 100 valid pulses, overrun=0.
- Bytes 0x5A, 0xC3 with ready held 0 after the first -> data stays 0x5A, overrun=1 after the second byte completes; ready=1 -> valid drops next cycle.
- 3 bits of 0xFF, then rxclk idle 70 clk cycles, then byte 0x81 -> only 0x81 is output; the partial byte is discarded.
- rst low mid-byte with valid=1 -> the following cycle data=0, valid=0, overrun=0, bit_cnt=0; after release the next full byte is received correctly.
- en dropped after 4 bits, raised again, then 0x3C sent -> single output 0x3C.
- DESER_SYNC_EN: stream 0x12, 0xA5, 0x77, 0x88 -> outputs only 0x77, 0x88.
